// File: rtl/stream_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : stream_packer
// Description : Packs RATIO WIDTH-bit valid/ready beats into one wide beat;
//               an input last flag flushes a partial word early.
//               Optional macro STREAM_PACKER_MSB_FIRST_EN puts the first beat
//               in the most significant slot.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_packer #(
   parameter int WIDTH = 16,
   parameter int RATIO = 2
) (
   input  logic                   i_clock,
   input  logic                   i_reset_n,
   input  logic [WIDTH-1:0]       i_in_data,
   input  logic                   i_in_valid,
   input  logic                   i_in_last,
   output logic                   o_in_ready,
   output logic [WIDTH*RATIO-1:0] o_out_data,
   output logic [RATIO-1:0]       o_out_keep,
   output logic                   o_out_last,
   output logic                   o_out_valid,
   input  logic                   i_out_ready
);

   localparam int c_CNT_W = (RATIO < 2) ? 1 : $clog2(RATIO);

   generate
      if (RATIO < 2) begin : g_ratio_check
         $error("stream_packer: RATIO must be >= 2");
      end
   endgenerate

   logic [WIDTH*RATIO-1:0] r_acc;
   logic [RATIO-1:0]       r_acc_keep;
   logic [c_CNT_W-1:0]     r_cnt;
   logic [WIDTH*RATIO-1:0] r_out_data;
   logic [RATIO-1:0]       r_out_keep;
   logic                   r_out_last;
   logic                   r_out_valid;

   logic                   w_in_ready;
   logic                   w_in_fire;
   logic                   w_out_fire;
   logic                   w_complete;
   logic [c_CNT_W-1:0]     w_slot;
   logic [WIDTH*RATIO-1:0] w_merged_data;
   logic [RATIO-1:0]       w_merged_keep;

   // Ready must never look at i_in_valid; the downstream skid breaks this path.
   assign w_in_ready = !r_out_valid | i_out_ready;
   assign w_in_fire  = i_in_valid & w_in_ready;
   assign w_out_fire = r_out_valid & i_out_ready;
   assign w_complete = (r_cnt == c_CNT_W'(RATIO - 1)) | i_in_last;

`ifdef STREAM_PACKER_MSB_FIRST_EN
   assign w_slot = c_CNT_W'(RATIO - 1) - r_cnt;
`else
   assign w_slot = r_cnt;
`endif

   always_comb begin
      w_merged_data = r_acc;
      w_merged_data[w_slot*WIDTH +: WIDTH] = i_in_data;
      w_merged_keep = r_acc_keep | (RATIO'(1) << w_slot);
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_acc       <= '0;
         r_acc_keep  <= '0;
         r_cnt       <= '0;
         r_out_data  <= '0;
         r_out_keep  <= '0;
         r_out_last  <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         if (w_in_fire && w_complete) begin
            // Completing beat reloads the output even if it is being accepted now.
            r_out_data  <= w_merged_data;
            r_out_keep  <= w_merged_keep;
            r_out_last  <= i_in_last;
            r_out_valid <= 1'b1;
            r_acc       <= '0;
            r_acc_keep  <= '0;
            r_cnt       <= '0;
         end else begin
            if (w_in_fire) begin
               r_acc      <= w_merged_data;
               r_acc_keep <= w_merged_keep;
               r_cnt      <= r_cnt + c_CNT_W'(1);
            end
            if (w_out_fire) begin
               r_out_valid <= 1'b0;
            end
         end
      end
   end

   assign o_in_ready  = w_in_ready;
   assign o_out_data  = r_out_data;
   assign o_out_keep  = r_out_keep;
   assign o_out_last  = r_out_last;
   assign o_out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_stream_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_stream_packer
// Description : Self-checking bench for stream_packer with a beat-list model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_packer;

   localparam int W = 16;
   localparam int R = 2;

   logic           i_clock = 1'b0;
   logic           i_reset_n = 1'b0;
   logic [W-1:0]   in_data = '0;
   logic           in_valid = 1'b0;
   logic           in_last = 1'b0;
   logic           out_ready = 1'b1;
   logic           o_in_ready;
   logic [W*R-1:0] o_out_data;
   logic [R-1:0]   o_out_keep;
   logic           o_out_last;
   logic           o_out_valid;

   int n_assert = 0;
   int n_fail   = 0;

   stream_packer #(.WIDTH(W), .RATIO(R)) dut (
      .i_clock     (i_clock),
      .i_reset_n   (i_reset_n),
      .i_in_data   (in_data),
      .i_in_valid  (in_valid),
      .i_in_last   (in_last),
      .o_in_ready  (o_in_ready),
      .o_out_data  (o_out_data),
      .o_out_keep  (o_out_keep),
      .o_out_last  (o_out_last),
      .o_out_valid (o_out_valid),
      .i_out_ready (out_ready)
   );

   always #5 i_clock = ~i_clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int slot_of(input int j);
`ifdef STREAM_PACKER_MSB_FIRST_EN
      return R - 1 - j;
`else
      return j;
`endif
   endfunction

   // ---------------- reference model: list of beats in the current packet ----
   typedef struct {
      logic [W*R-1:0] data;
      logic [R-1:0]   keep;
      logic           last;
   } word_t;

   logic [W-1:0]   cur_q[$];
   word_t          rx_q[$];
   logic           m_valid = 1'b0;
   logic           m_fresh = 1'b1;
   word_t          m_word;

   always @(negedge i_clock) begin
      logic exp_rdy, in_fire, out_fire;
      word_t w;
      #2;
      if (!i_reset_n) begin
         cur_q.delete();
         m_valid = 1'b0;
         m_fresh = 1'b1;
         chk("rst_valid", 64'(o_out_valid), 64'd0);
         chk("rst_data",  64'(o_out_data),  64'd0);
         chk("rst_keep",  64'(o_out_keep),  64'd0);
         chk("rst_last",  64'(o_out_last),  64'd0);
      end else begin
         exp_rdy = !m_valid || out_ready;
         chk("in_ready",  64'(o_in_ready),  64'(exp_rdy));
         chk("out_valid", 64'(o_out_valid), 64'(m_valid));
         if (m_fresh) chk("idle_data", 64'(o_out_data), 64'd0);
         if (m_valid) begin
            chk("out_data", 64'(o_out_data), 64'(m_word.data));
            chk("out_keep", 64'(o_out_keep), 64'(m_word.keep));
            chk("out_last", 64'(o_out_last), 64'(m_word.last));
         end
         in_fire  = in_valid && exp_rdy;
         out_fire = m_valid && out_ready;
         if (out_fire) begin
            w.data = o_out_data; w.keep = o_out_keep; w.last = o_out_last;
            rx_q.push_back(w);
            m_valid = 1'b0;
         end
         if (in_fire) begin
            cur_q.push_back(in_data);
            if (cur_q.size() == R || in_last) begin
               m_word.data = '0;
               m_word.keep = '0;
               m_word.last = in_last;
               for (int j = 0; j < cur_q.size(); j++) begin
                  m_word.data[slot_of(j)*W +: W] = cur_q[j];
                  m_word.keep[slot_of(j)] = 1'b1;
               end
               m_valid = 1'b1;
               m_fresh = 1'b0;
               cur_q.delete();
            end
         end
      end
   end

   // ---------------- random ready during the streaming phase -----------------
   logic rnd_ready = 1'b0;
   always @(negedge i_clock) begin
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
   end

   // Offer a beat and return at the edge where it is accepted.
   task automatic send(input logic [W-1:0] d, input logic l);
      int t;
      t = 0;
      @(negedge i_clock);
      in_data = d; in_last = l; in_valid = 1'b1;
      #3;
      while (!o_in_ready && t < 500) begin
         @(negedge i_clock); #3; t++;
      end
      if (!o_in_ready) begin
         chk("send_timeout", 64'd1, 64'd0);
         return;
      end
      @(posedge i_clock);
   endtask

   task automatic idle();
      @(negedge i_clock);
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   logic [W*R-1:0] exp_single;
   logic [R-1:0]   exp_single_keep;

   initial begin
      int expv;
      // 1: reset and idle
      repeat (3) @(negedge i_clock);
      #4 i_reset_n = 1'b1;
      repeat (1000) @(negedge i_clock);
      #3;
      chk("t1_ready", 64'(o_in_ready), 64'd1);
      chk("t1_data",  64'(o_out_data), 64'd0);
      chk("t1_valid", 64'(o_out_valid), 64'd0);

      // 2: two-beat word, one cycle of valid
      out_ready = 1'b1;
      send(16'h0001, 1'b0);
      send(16'h0002, 1'b0);
      idle(); #3;
      chk("t2_data",  64'(o_out_data), 64'h0000_0000_0002_0001);
      chk("t2_keep",  64'(o_out_keep), 64'b11);
      chk("t2_last",  64'(o_out_last), 64'd0);
      chk("t2_valid", 64'(o_out_valid), 64'd1);
      @(negedge i_clock); #3;
      chk("t2_valid_drop", 64'(o_out_valid), 64'd0);

      // 3: single-beat packet
`ifdef STREAM_PACKER_MSB_FIRST_EN
      exp_single = 32'h00AA_0000; exp_single_keep = 2'b10;
`else
      exp_single = 32'h0000_00AA; exp_single_keep = 2'b01;
`endif
      send(16'h00AA, 1'b1);
      idle(); #3;
      chk("t3_data", 64'(o_out_data), 64'(exp_single));
      chk("t3_keep", 64'(o_out_keep), 64'(exp_single_keep));
      chk("t3_last", 64'(o_out_last), 64'd1);

      // 4: stall with beats 3-4 waiting upstream
      @(negedge i_clock);
      out_ready = 1'b0;
      send(16'h0001, 1'b0);
      send(16'h0002, 1'b0);
      @(negedge i_clock);
      in_data = 16'h0003; in_last = 1'b0; in_valid = 1'b1;
      for (int k = 0; k < 20; k++) begin
         #3;
         chk("t4_hold_data", 64'(o_out_data), 64'h0002_0001);
         chk("t4_hold_rdy",  64'(o_in_ready), 64'd0);
         @(negedge i_clock);
      end
      out_ready = 1'b1;
      #3 chk("t4_rdy_up", 64'(o_in_ready), 64'd1);
      @(posedge i_clock);
      send(16'h0004, 1'b0);
      idle(); #3;
      chk("t4_second", 64'(o_out_data), 64'h0004_0003);
      chk("t4_keep",   64'(o_out_keep), 64'b11);

      // 5: bursty incrementing stream with last every 7th beat
      repeat (3) @(negedge i_clock);
      rx_q.delete();
      rnd_ready = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         while ($urandom_range(0, 1) == 0) idle();
         send(W'(i), (i % 7 == 6) || (i == 999));
      end
      idle();
      rnd_ready = 1'b0;
      @(negedge i_clock);
      out_ready = 1'b1;
      repeat (10) @(negedge i_clock);
      #3;
      expv = 0;
      foreach (rx_q[n]) begin
         for (int j = 0; j < R; j++) begin
            if (rx_q[n].keep[slot_of(j)]) begin
               chk("t5_stream", 64'(rx_q[n].data[slot_of(j)*W +: W]), 64'(expv));
               expv++;
            end
         end
      end
      chk("t5_count", 64'(expv), 64'd1000);

      // 6a: async reset drops a stalled output word immediately
      out_ready = 1'b0;
      send(16'h0033, 1'b0);
      send(16'h0044, 1'b0);
      idle();
      @(posedge i_clock);
      #2 i_reset_n = 1'b0;
      #1;
      chk("t6_valid_drop", 64'(o_out_valid), 64'd0);
      chk("t6_data_clr",   64'(o_out_data),  64'd0);
      @(negedge i_clock);
      #3 i_reset_n = 1'b1;
      out_ready = 1'b1;

      // 6b: partial word discarded by reset
      send(16'h0055, 1'b0);
      #2 i_reset_n = 1'b0;
      in_valid = 1'b0;
      #1 chk("t6b_valid", 64'(o_out_valid), 64'd0);
      @(negedge i_clock);
      #3 i_reset_n = 1'b1;
      send(16'h0011, 1'b0);
      send(16'h0022, 1'b0);
      idle(); #3;
      chk("t6b_data", 64'(o_out_data), 64'h0022_0011);
      chk("t6b_keep", 64'(o_out_keep), 64'b11);
      chk("t6b_valid", 64'(o_out_valid), 64'd1);
      repeat (3) @(negedge i_clock);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
